mipi_raw_unpack_nx: RTL

Parametrised successor to the fixed RAW10 pixel selector: converts a CSI-2 payload byte stream into 4 pixels per output beat. Supports RAW8, RAW10 and RAW12, with the mode latched per packet. Provides valid/ready backpressure on both sides, end-of-packet flush and truncation/mode error flags. Sits between the CSI-2 lane merger (byte stream) and the ISP pixel pipeline; status is read through the wishbone register block.

---
 rtl/mipi_raw_unpack_nx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mipi_raw_unpack_nx.sv
// CSI-2 payload byte stream to 4-pixel beats for RAW8/RAW10/RAW12.
// Mode is latched per packet; a byte accumulator decouples input beats from pixel groups.
module mipi_raw_unpack_nx #(
   parameter int unsigned IN_BYTES  = 4,
   parameter int unsigned PIX_W     = 12,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned BUF_BYTES = IN_BYTES + 6
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic [1:0]            mode_i,
   input  logic [IN_BYTES*8-1:0] in_data,
   input  logic [IN_BYTES-1:0]   in_keep,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [4*PIX_W-1:0]    out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      pix_cnt_o,
   output logic                  err_trunc_o,
   output logic                  err_mode_o,
   input  logic                  err_clr_i
);

   localparam int unsigned IN_W  = IN_BYTES * 8;
   localparam int unsigned BUF_W = BUF_BYTES * 8;
   localparam int unsigned OUT_W = 4 * PIX_W;
   localparam int unsigned CW    = $clog2(BUF_BYTES + IN_BYTES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [OUT_W-1:0]   data_d;
   logic               valid_d, last_d;
   logic [CNT_W-1:0]   pkt_q, pkt_d, pix_cnt_d;
   logic               trunc_d, emode_d;
   logic               en_q;

   logic [CW-1:0]      g;
   logic [CW-1:0]      push_n;
   logic [CW-1:0]      cnt_pop;
   logic [CW-1:0]      rem;
   logic               load;
   logic               load_last;
   logic               in_fire;
   logic [IN_W-1:0]    push_vec;
   logic [BUF_W-1:0]   buf_pop;
   logic [7:0]         b [6];
   logic [OUT_W-1:0]   dec_data;

   // Group size and number of bytes offered by this beat
   always_comb begin
      case (mode_q)
         2'b01:   g = CW'(5);
         2'b10:   g = CW'(6);
         default: g = CW'(4);
      endcase
      push_n   = '0;
      push_vec = '0;
      for (int i = 0; i < IN_BYTES; i++) begin
         push_n = push_n + CW'(in_keep[i]);
         if (in_keep[i]) push_vec[i*8 +: 8] = in_data[i*8 +: 8];
      end
   end

   // Pop/accept handshake; in_ready is held low until the first cycle after reset
   always_comb begin
      load     = (state_q != IDLE) && (cnt_q >= g) && (!out_valid || out_ready);
      rem      = cnt_q - g;
      cnt_pop  = load ? rem : cnt_q;
      in_ready = en_q && (state_q != FLUSH) &&
                 ((cnt_pop + CW'(IN_BYTES)) <= CW'(BUF_BYTES));
      in_fire  = in_valid && in_ready;
      // A group popped while the final beat lands can itself be the last one
      load_last = ((state_q == FLUSH) && (rem < g)) ||
                  ((state_q == RUN) && in_fire && in_last && ((rem + push_n) < g));
   end

   // Decode the oldest group in the accumulator
   always_comb begin
      for (int k = 0; k < 6; k++) b[k] = buf_q[k*8 +: 8];
      dec_data = '0;
      case (mode_q)
         2'b01: begin
            for (int n = 0; n < 4; n++)
               dec_data[n*PIX_W +: PIX_W] = PIX_W'({b[n], b[4][2*n +: 2]});
         end
         2'b10: begin
            dec_data[0*PIX_W +: PIX_W] = PIX_W'({b[0], b[2][3:0]});
            dec_data[1*PIX_W +: PIX_W] = PIX_W'({b[1], b[2][7:4]});
            dec_data[2*PIX_W +: PIX_W] = PIX_W'({b[3], b[5][3:0]});
            dec_data[3*PIX_W +: PIX_W] = PIX_W'({b[4], b[5][7:4]});
         end
         default: begin
            for (int n = 0; n < 4; n++)
               dec_data[n*PIX_W +: PIX_W] = PIX_W'(b[n]);
         end
      endcase
   end

   // Next-state, accumulator, output stage and status
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      pkt_d     = pkt_q;
      pix_cnt_d = pix_cnt_o;
      data_d    = out_data;
      valid_d   = out_valid;
      last_d    = out_last;
      trunc_d   = err_trunc_o;
      emode_d   = err_mode_o;

      buf_pop = load ? (buf_q >> {g, 3'b000}) : buf_q;
      buf_d   = buf_pop | (in_fire ? (BUF_W'(push_vec) << {cnt_pop, 3'b000}) : '0);
      cnt_d   = cnt_pop + (in_fire ? push_n : '0);

      if (out_valid && out_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
      if (load) begin
         data_d  = dec_data;
         valid_d = 1'b1;
         last_d  = load_last;
         pkt_d   = pkt_q + CNT_W'(4);
      end

      if (err_clr_i) begin
         trunc_d = 1'b0;
         emode_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (in_fire) begin
               mode_d  = mode_i;
               pkt_d   = '0;
               if (mode_i == 2'b11) emode_d = 1'b1;
               state_d = in_last ? FLUSH : RUN;
            end
         end
         RUN: begin
            if (in_fire && in_last) state_d = FLUSH;
         end
         FLUSH: begin
            if (cnt_q < g) begin
               if (cnt_q != '0) trunc_d = 1'b1;
               cnt_d     = '0;
               buf_d     = '0;
               pix_cnt_d = pkt_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mode_q      <= 2'b00;
         buf_q       <= '0;
         cnt_q       <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         pkt_q       <= '0;
         pix_cnt_o   <= '0;
         err_trunc_o <= 1'b0;
         err_mode_o  <= 1'b0;
         en_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         out_data    <= data_d;
         out_valid   <= valid_d;
         out_last    <= last_d;
         pkt_q       <= pkt_d;
         pix_cnt_o   <= pix_cnt_d;
         err_trunc_o <= trunc_d;
         err_mode_o  <= emode_d;
         en_q        <= 1'b1;
      end
   end

endmodule
